// File: rtl/image_load_pkg.sv
// Shared command codes, controller state encoding and error-flag bit positions
// for the SPI-to-frame-memory load controller.
package image_load_pkg;

    localparam logic [7:0] CMD_LOAD  = 8'hA5;
    localparam logic [7:0] CMD_START = 8'h3C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LOAD,
        ST_COMPUTE,
        ST_DISCARD
    } state_t;

    localparam int ERR_SHORT   = 0;
    localparam int ERR_BADCMD  = 1;
    localparam int ERR_OVERRUN = 2;

endpackage

// File: rtl/pixel_addr_counter.sv
// Raster pixel address counter: synchronous clear to zero, increment, and a
// terminal flag that is high while the count sits on the last pixel address.
module pixel_addr_counter #(
    parameter int addrBits  = 12,
    parameter int lastValue = 4095
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                clear_i,
    input  logic                inc_i,
    output logic [addrBits-1:0] count_o,
    output logic                terminal_o
);

    localparam logic [addrBits-1:0] LAST = addrBits'(lastValue);

    logic [addrBits-1:0] count_q;
    logic [addrBits-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o    = count_q;
    assign terminal_o = (count_q == LAST);

endmodule

// File: rtl/image_load_ctrl.sv
// Sequences received SPI bytes into frame memory, decodes the per-transaction
// command byte, and hands a resident frame to the edge core via start/done.
module image_load_ctrl
    import image_load_pkg::*;
#(
    parameter int imgWidth  = 64,
    parameter int imgHeight = 64,
    parameter int addrBits  = $clog2(imgWidth * imgHeight)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                byteValid,
    input  logic [7:0]          byteData,
    input  logic                ncsSync,
    input  logic                computeDone,
    output logic                memWriteEnable,
    output logic [addrBits-1:0] memWriteAddr,
    output logic [7:0]          memWriteData,
    output logic                frameValid,
    output logic                startCompute,
    output logic                busy,
    output logic [2:0]          errorFlags,
    output state_t              debug_state_o
);

    // Handshake: byteValid is a single-cycle qualifier for byteData; each
    // memWriteEnable cycle carries exactly one address/data pair, and
    // startCompute is a single-cycle request answered later by computeDone.

    state_t              state_q, state_d;
    logic                wr_en_q, wr_en_d;
    logic [addrBits-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                frame_valid_q, frame_valid_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic [2:0]          err_q, err_d;

    logic                addr_clear;
    logic                addr_inc;
    logic [addrBits-1:0] pix_addr;
    logic                pix_last;

    pixel_addr_counter #(
        .addrBits  (addrBits),
        .lastValue (imgWidth * imgHeight - 1)
    ) u_addr (
        .clk_i      (clk),
        .reset_i    (reset),
        .clear_i    (addr_clear),
        .inc_i      (addr_inc),
        .count_o    (pix_addr),
        .terminal_o (pix_last)
    );

    always_comb begin
        state_d       = state_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_valid_d = frame_valid_q;
        start_d       = 1'b0;
        busy_d        = busy_q;
        err_d         = err_q;
        addr_clear    = 1'b0;
        addr_inc      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!ncsSync) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (byteValid) begin
                    if (byteData == CMD_LOAD) begin
                        addr_clear    = 1'b1;
                        frame_valid_d = 1'b0;
                        err_d         = '0;
                        state_d       = ncsSync ? ST_IDLE : ST_LOAD;
                    end else if (byteData == CMD_START && frame_valid_q) begin
                        // Compute entry ignores chip select, even if it rises now.
                        start_d = 1'b1;
                        busy_d  = 1'b1;
                        state_d = ST_COMPUTE;
                    end else begin
                        err_d[ERR_BADCMD] = 1'b1;
                        state_d           = ncsSync ? ST_IDLE : ST_DISCARD;
                    end
                end else if (ncsSync) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (byteValid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = pix_addr;
                    wr_data_d = byteData;
                    addr_inc  = 1'b1;
                end
                if (byteValid && pix_last) begin
                    frame_valid_d = 1'b1;
                    state_d       = ST_DISCARD;
                end else if (ncsSync) begin
                    err_d[ERR_SHORT] = 1'b1;
                    state_d          = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                if (byteValid) begin
                    err_d[ERR_OVERRUN] = 1'b1;
                end
                if (computeDone) begin
                    busy_d  = 1'b0;
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (ncsSync) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_valid_q <= 1'b0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_valid_q <= frame_valid_d;
            start_q       <= start_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

    assign memWriteEnable = wr_en_q;
    assign memWriteAddr   = wr_addr_q;
    assign memWriteData   = wr_data_q;
    assign frameValid     = frame_valid_q;
    assign startCompute   = start_q;
    assign busy           = busy_q;
    assign errorFlags     = err_q;
    assign debug_state_o  = state_q;

endmodule

// File: tb/tb_image_load_ctrl.sv
// Directed bench for image_load_ctrl: full/short loads, compute handshake,
// bad commands, last-pixel/chip-select coincidence and mid-load reset.
module tb_image_load_ctrl;
    import image_load_pkg::*;

    localparam int W  = 64;
    localparam int H  = 64;
    localparam int N  = W * H;
    localparam int AB = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          byteValid;
    logic [7:0]    byteData;
    logic          ncsSync;
    logic          computeDone;
    logic          memWriteEnable;
    logic [AB-1:0] memWriteAddr;
    logic [7:0]    memWriteData;
    logic          frameValid;
    logic          startCompute;
    logic          busy;
    logic [2:0]    errorFlags;
    state_t        dbg_state;

    int errors = 0;
    int checks = 0;

    image_load_ctrl #(.imgWidth(W), .imgHeight(H), .addrBits(AB)) dut (
        .clk            (clk),
        .reset          (reset),
        .byteValid      (byteValid),
        .byteData       (byteData),
        .ncsSync        (ncsSync),
        .computeDone    (computeDone),
        .memWriteEnable (memWriteEnable),
        .memWriteAddr   (memWriteAddr),
        .memWriteData   (memWriteData),
        .frameValid     (frameValid),
        .startCompute   (startCompute),
        .busy           (busy),
        .errorFlags     (errorFlags),
        .debug_state_o  (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        byteValid = 1'b1;
        byteData  = b;
        tick();
        byteValid = 1'b0;
    endtask

    task automatic cs_low();
        tick();
        ncsSync = 1'b0;
        tick();
    endtask

    task automatic cs_high();
        tick();
        ncsSync = 1'b1;
        tick();
        tick();
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load_pixels(input int count);
        for (int i = 0; i < count; i++) begin
            send_byte(8'(i));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; ncsSync = 1'b1; byteValid = 1'b0; byteData = '0; computeDone = 1'b0;
        tick();
        tick();
        checks++;
        if ({memWriteEnable, memWriteAddr, memWriteData, frameValid, startCompute, busy, errorFlags} !== '0
            || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_values: we=%b addr=%0d data=%h fv=%b start=%b busy=%b err=%b state=%0d, required all zero/IDLE",
                     memWriteEnable, memWriteAddr, memWriteData, frameValid, startCompute, busy, errorFlags, dbg_state);
        end
        reset = 1'b0;
    endtask

    task automatic test_full_load();
        cs_low();
        send_byte(CMD_LOAD);
        checks++;
        if (memWriteEnable !== 1'b0 || dbg_state !== ST_LOAD) begin
            errors++;
            $display("FAIL load_cmd: we=%b state=%0d, required we=0 state=LOAD", memWriteEnable, dbg_state);
        end
        for (int i = 0; i < N; i++) begin
            send_byte(8'(i));
            checks++;
            if (memWriteEnable !== 1'b1 || memWriteAddr !== AB'(i) || memWriteData !== 8'(i)
                || frameValid !== (i == N - 1)) begin
                errors++;
                $display("FAIL full_write[%0d]: we=%b addr=%0d data=%h fv=%b, required we=1 addr=%0d data=%h fv=%b",
                         i, memWriteEnable, memWriteAddr, memWriteData, frameValid, i, 8'(i), (i == N - 1));
            end
        end
        tick();
        checks++;
        if (memWriteEnable !== 1'b0 || errorFlags !== 3'b000 || frameValid !== 1'b1) begin
            errors++;
            $display("FAIL full_done: we=%b err=%b fv=%b, required we=0 err=000 fv=1", memWriteEnable, errorFlags, frameValid);
        end
        send_byte(8'h55);
        checks++;
        if (memWriteEnable !== 1'b0 || dbg_state !== ST_DISCARD) begin
            errors++;
            $display("FAIL beyond_frame: we=%b state=%0d, required we=0 state=DISCARD", memWriteEnable, dbg_state);
        end
        cs_high();
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL full_idle: state=%0d, required IDLE", dbg_state);
        end
    endtask

    task automatic test_short_frame();
        cs_low();
        send_byte(CMD_LOAD);
        checks++;
        if (frameValid !== 1'b0) begin
            errors++;
            $display("FAIL load_clears_fv: fv=%b, required 0", frameValid);
        end
        // back-to-back pixels on consecutive cycles
        tick();
        byteValid = 1'b1;
        byteData  = 8'd0;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (memWriteEnable !== 1'b1 || memWriteAddr !== AB'(i) || memWriteData !== 8'(i)) begin
                errors++;
                $display("FAIL short_write[%0d]: we=%b addr=%0d data=%h, required we=1 addr=%0d data=%h",
                         i, memWriteEnable, memWriteAddr, memWriteData, i, 8'(i));
            end
            if (i < 99) begin
                byteData = 8'(i + 1);
            end else begin
                byteValid = 1'b0;
                ncsSync   = 1'b1;
            end
        end
        tick();
        checks++;
        if (memWriteEnable !== 1'b0 || frameValid !== 1'b0 || errorFlags !== 3'b001 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL short_end: we=%b fv=%b err=%b state=%0d, required we=0 fv=0 err=001 IDLE",
                     memWriteEnable, frameValid, errorFlags, dbg_state);
        end
    endtask

    task automatic test_compute();
        cs_low();
        send_byte(CMD_LOAD);
        load_pixels(N);
        cs_high();
        cs_low();
        send_byte(CMD_START);
        checks++;
        if (startCompute !== 1'b1 || busy !== 1'b1 || dbg_state !== ST_COMPUTE) begin
            errors++;
            $display("FAIL start_pulse: start=%b busy=%b state=%0d, required 1 1 COMPUTE", startCompute, busy, dbg_state);
        end
        tick();
        checks++;
        if (startCompute !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_one_cycle: start=%b busy=%b, required 0 1", startCompute, busy);
        end
        send_byte(8'h99);
        checks++;
        if (memWriteEnable !== 1'b0 || errorFlags !== 3'b100) begin
            errors++;
            $display("FAIL overrun: we=%b err=%b, required we=0 err=100", memWriteEnable, errorFlags);
        end
        tick();
        ncsSync = 1'b1;
        tick();
        tick();
        checks++;
        if (dbg_state !== ST_COMPUTE || busy !== 1'b1) begin
            errors++;
            $display("FAIL ncs_ignored: state=%0d busy=%b, required COMPUTE 1", dbg_state, busy);
        end
        computeDone = 1'b1;
        tick();
        computeDone = 1'b0;
        checks++;
        if (busy !== 1'b0 || dbg_state !== ST_DISCARD) begin
            errors++;
            $display("FAIL done: busy=%b state=%0d, required 0 DISCARD", busy, dbg_state);
        end
        tick();
        checks++;
        if (dbg_state !== ST_IDLE || errorFlags !== 3'b100 || frameValid !== 1'b1) begin
            errors++;
            $display("FAIL post_compute: state=%0d err=%b fv=%b, required IDLE 100 1", dbg_state, errorFlags, frameValid);
        end
    endtask

    task automatic test_bad_cmd();
        logic [7:0] cmds [2];
        cmds[0] = CMD_START;
        cmds[1] = 8'h77;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            cs_low();
            send_byte(cmds[k]);
            checks++;
            if (startCompute !== 1'b0 || errorFlags !== 3'b010 || dbg_state !== ST_DISCARD) begin
                errors++;
                $display("FAIL bad_cmd[%h]: start=%b err=%b state=%0d, required 0 010 DISCARD",
                         cmds[k], startCompute, errorFlags, dbg_state);
            end
            tick();
            checks++;
            if (startCompute !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL bad_cmd_nostart[%h]: start=%b busy=%b, required 0 0", cmds[k], startCompute, busy);
            end
            cs_high();
        end
    endtask

    task automatic test_last_pixel_cs();
        do_reset();
        cs_low();
        send_byte(CMD_LOAD);
        load_pixels(N - 1);
        tick();
        byteValid = 1'b1;
        byteData  = 8'hFF;
        ncsSync   = 1'b1;
        tick();
        byteValid = 1'b0;
        checks++;
        if (memWriteEnable !== 1'b1 || memWriteAddr !== AB'(N - 1) || memWriteData !== 8'hFF
            || frameValid !== 1'b1 || errorFlags !== 3'b000) begin
            errors++;
            $display("FAIL last_with_cs: we=%b addr=%0d data=%h fv=%b err=%b, required 1 %0d ff 1 000",
                     memWriteEnable, memWriteAddr, memWriteData, frameValid, errorFlags, N - 1);
        end
        tick();
        checks++;
        if (dbg_state !== ST_IDLE || frameValid !== 1'b1 || errorFlags !== 3'b000) begin
            errors++;
            $display("FAIL last_with_cs_idle: state=%0d fv=%b err=%b, required IDLE 1 000", dbg_state, frameValid, errorFlags);
        end
    endtask

    task automatic test_reset_mid_load();
        cs_low();
        send_byte(CMD_LOAD);
        load_pixels(2000);
        tick();
        reset     = 1'b1;
        byteValid = 1'b1;
        byteData  = 8'hD0;
        tick();
        byteValid = 1'b0;
        checks++;
        if ({memWriteEnable, memWriteAddr, memWriteData, frameValid, startCompute, busy, errorFlags} !== '0
            || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_mid_load: we=%b addr=%0d data=%h fv=%b start=%b busy=%b err=%b state=%0d, required all zero/IDLE",
                     memWriteEnable, memWriteAddr, memWriteData, frameValid, startCompute, busy, errorFlags, dbg_state);
        end
        reset   = 1'b0;
        ncsSync = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_short_frame();
        test_compute();
        test_bad_cmd();
        test_last_pixel_cs();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
